// File: rtl/ingress_credit_shaper.sv
// Per-port ingress shaper: screens headers, queues legal packets and
// issues them to the switch port only while port FIFO credit remains.
module ingress_credit_shaper #(
   parameter int PACKET_WIDTH = 16,
   parameter int DEPTH        = 8,
   parameter int QDEPTH       = 4,
   parameter int PORT_ID      = 0,
   parameter int INIT_CYCLES  = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [PACKET_WIDTH-1:0]      s_pkt,
   input  logic                         pause,
   output logic                         sw_valid_in,
   output logic [PACKET_WIDTH-1:0]      sw_pkt,
   output logic [3:0]                   sw_target,
   input  logic                         sw_pop,
   output logic [$clog2(DEPTH+1)-1:0]   credit,
   output logic [$clog2(QDEPTH+1)-1:0]  q_count,
   output logic [15:0]                  bad_cnt,
   output logic [15:0]                  sent_cnt,
   output logic                         credit_err
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int QW = $clog2(QDEPTH+1);
   localparam int PW = $clog2(QDEPTH);
   localparam int IW = $clog2(INIT_CYCLES+1);
   localparam logic [CW-1:0] CMAX  = CW'(DEPTH);
   localparam logic [QW-1:0] QFULL = QW'(QDEPTH);
   localparam logic [3:0]    PID   = 4'(PORT_ID);
   localparam logic [IW-1:0] ILAST = IW'(INIT_CYCLES-1);

   typedef enum logic [1:0] {INIT, RUN, PAUSE} state_t;

   state_t                  state;
   logic [IW-1:0]           init_cnt;
   logic [PACKET_WIDTH-1:0] mem [QDEPTH];
   logic [PW-1:0]           wptr;
   logic [PW-1:0]           rptr;
   logic [3:0]              tgt;
   logic                    legal;
   logic                    hs;
   logic                    enq;
   logic                    rej;
   logic                    issue;

   assign s_ready = (state != INIT) && (q_count != QFULL);
   assign tgt     = s_pkt[7:4];
   assign legal   = (tgt != 4'd0) && !tgt[PORT_ID[1:0]]
                 && (s_pkt[3:0] == PID);
   assign hs      = s_valid && s_ready;
   assign enq     = hs && legal;
   assign rej     = hs && !legal;
   assign issue   = (state == RUN) && (q_count != '0)
                 && (credit != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         unique case (state)
            INIT: begin
               if (init_cnt == ILAST) state <= RUN;
               else init_cnt <= init_cnt + IW'(1);
            end
            RUN:     if (pause)  state <= PAUSE;
            PAUSE:   if (!pause) state <= RUN;
            default: state <= INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         q_count <= '0;
      end else begin
         if (enq)   wptr <= wptr + PW'(1);
         if (issue) rptr <= rptr + PW'(1);
         if (enq && !issue)      q_count <= q_count + QW'(1);
         else if (!enq && issue) q_count <= q_count - QW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (enq) mem[wptr] <= s_pkt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_valid_in <= 1'b0;
         sw_pkt      <= '0;
         sw_target   <= '0;
         credit      <= CMAX;
         bad_cnt     <= '0;
         sent_cnt    <= '0;
         credit_err  <= 1'b0;
      end else begin
         sw_valid_in <= issue;
         if (issue) begin
            sw_pkt    <= mem[rptr];
            sw_target <= mem[rptr][7:4];
            if (sent_cnt != 16'hFFFF) sent_cnt <= sent_cnt + 16'd1;
         end
         if (rej && bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
         // A pop with the FIFO already fully credited is a protocol error
         unique case (1'b1)
            issue && !sw_pop:
               credit <= credit - CW'(1);
            !issue && sw_pop && (credit != CMAX):
               credit <= credit + CW'(1);
            !issue && sw_pop && (credit == CMAX):
               credit_err <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ingress_credit_shaper.sv
// Bench for ingress_credit_shaper: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_ingress_credit_shaper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_pkt = '0;
   logic        pause = 1'b0;
   logic        sw_valid_in;
   logic [15:0] sw_pkt;
   logic [3:0]  sw_target;
   logic        sw_pop = 1'b0;
   logic [3:0]  credit;
   logic [2:0]  q_count;
   logic [15:0] bad_cnt;
   logic [15:0] sent_cnt;
   logic        credit_err;

   ingress_credit_shaper dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_pkt(s_pkt),
      .pause(pause),
      .sw_valid_in(sw_valid_in), .sw_pkt(sw_pkt),
      .sw_target(sw_target), .sw_pop(sw_pop),
      .credit(credit), .q_count(q_count),
      .bad_cnt(bad_cnt), .sent_cnt(sent_cnt),
      .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s got %0h want %0h at %0t",
                     name, act, exp, $time);
      end
   endtask

   // Reference model: a packet queue plus credit arithmetic
   logic [15:0] mq[$];
   int          m_n;
   int          m_credit;
   int          m_bad;
   int          m_sent;
   bit          m_err;
   bit          m_paused;
   bit          m_valid;
   logic [15:0] m_pkt;
   bit          m_ready;
   bit          m_took;

   function automatic bit m_legal(input logic [15:0] p);
      logic [3:0] t;
      t = p[7:4];
      return (t != 4'd0) && !t[0] && (p[3:0] == 4'd0);
   endfunction

   task automatic m_reset();
      mq.delete();
      m_n = 0; m_credit = 8; m_bad = 0; m_sent = 0;
      m_err = 0; m_paused = 0; m_valid = 0; m_pkt = '0;
      m_ready = 0; m_took = 0;
   endtask

   task automatic m_step(input bit r, input bit v,
                         input logic [15:0] p,
                         input bit pz, input bit pp);
      bit pre_init;
      bit iss;
      bit hs;
      if (r) begin
         m_reset();
         return;
      end
      pre_init = m_n < 20;
      iss = !pre_init && !m_paused && mq.size() > 0 && m_credit > 0;
      hs = v && m_ready;
      m_valid = iss;
      if (iss) begin
         m_pkt = mq.pop_front();
         m_credit--;
         if (m_sent < 65535) m_sent++;
      end
      if (pp) begin
         m_credit++;
         if (m_credit > 8) begin
            m_credit = 8;
            m_err = 1;
         end
      end
      if (hs) begin
         if (m_legal(p)) mq.push_back(p);
         else if (m_bad < 65535) m_bad++;
      end
      m_paused = pre_init ? 1'b0 : pz;
      if (m_n < 1000) m_n++;
      m_ready = (m_n >= 20) && (mq.size() < 4);
      m_took = hs;
   endtask

   task automatic cyc(input bit r, input bit v, input logic [15:0] p,
                      input bit pz, input bit pp);
      rst = r; s_valid = v; s_pkt = p; pause = pz; sw_pop = pp;
      @(posedge clk);
      m_step(r, v, p, pz, pp);
      #1;
      chk("s_ready", 32'(s_ready), 32'(m_ready));
      chk("sw_valid_in", 32'(sw_valid_in), 32'(m_valid));
      chk("sw_pkt", 32'(sw_pkt), 32'(m_pkt));
      chk("sw_target", 32'(sw_target), 32'(m_pkt[7:4]));
      chk("credit", 32'(credit), m_credit);
      chk("q_count", 32'(q_count), mq.size());
      chk("bad_cnt", 32'(bad_cnt), m_bad);
      chk("sent_cnt", 32'(sent_cnt), m_sent);
      chk("credit_err", 32'(credit_err), 32'(m_err));
   endtask

   task automatic idle();
      cyc(0, 0, 16'h0, 0, 0);
   endtask

   task automatic reset_init();
      cyc(1, 0, 16'h0, 0, 0);
      repeat (20) idle();
   endtask

   typedef struct {
      bit          v;
      logic [15:0] pkt;
      bit          e_valid;
      logic [3:0]  e_tgt;
      int          e_credit;
      int          e_q;
      int          e_sent;
      int          e_bad;
   } vec_t;

   vec_t tv[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int pulses;
      bit r;
      bit v;
      bit pz;
      bit pp;
      logic [3:0] t;
      logic [3:0] sr;

      tv[0] = '{1, 16'h0120, 0, 4'd0, 8, 1, 0, 0};
      tv[1] = '{1, 16'h0380, 1, 4'd2, 7, 1, 1, 0};
      tv[2] = '{0, 16'h0000, 1, 4'd8, 6, 0, 2, 0};
      tv[3] = '{0, 16'h0000, 0, 4'd8, 6, 0, 2, 0};
      tv[4] = '{1, 16'h0000, 0, 4'd8, 6, 0, 2, 1};
      tv[5] = '{1, 16'h0011, 0, 4'd8, 6, 0, 2, 2};
      tv[6] = '{1, 16'h0010, 0, 4'd8, 6, 0, 2, 3};
      tv[7] = '{0, 16'h0000, 0, 4'd8, 6, 0, 2, 3};

      // Reset values and the init window
      cyc(1, 0, 16'h0, 0, 0);
      chk("rst_ready", 32'(s_ready), 0);
      chk("rst_credit", 32'(credit), 8);
      chk("rst_valid", 32'(sw_valid_in), 0);
      chk("rst_pkt", 32'(sw_pkt), 0);
      chk("rst_err", 32'(credit_err), 0);
      for (int k = 1; k <= 20; k++) begin
         idle();
         chk("init_ready", 32'(s_ready), (k == 20) ? 1 : 0);
      end

      // Legal issue and header screening
      for (int i = 0; i < 8; i++) begin
         cyc(0, tv[i].v, tv[i].pkt, 0, 0);
         chk("tv_valid", 32'(sw_valid_in), 32'(tv[i].e_valid));
         chk("tv_target", 32'(sw_target), 32'(tv[i].e_tgt));
         chk("tv_credit", 32'(credit), tv[i].e_credit);
         chk("tv_q", 32'(q_count), tv[i].e_q);
         chk("tv_sent", 32'(sent_cnt), tv[i].e_sent);
         chk("tv_bad", 32'(bad_cnt), tv[i].e_bad);
      end

      // Credit exhaustion then credit return
      reset_init();
      acc = 0;
      for (int i = 0; i < 40 && acc < 12; i++) begin
         cyc(0, 1, {8'(acc), 8'h20}, 0, 0);
         if (m_took) acc++;
      end
      chk("t3_accepted", acc, 12);
      chk("t3_credit", 32'(credit), 0);
      chk("t3_q", 32'(q_count), 4);
      chk("t3_ready", 32'(s_ready), 0);
      chk("t3_sent", 32'(sent_cnt), 8);
      repeat (3) begin
         cyc(0, 0, 16'h0, 0, 1);
         idle();
      end
      chk("t3_credit2", 32'(credit), 0);
      chk("t3_q2", 32'(q_count), 1);
      chk("t3_sent2", 32'(sent_cnt), 11);

      // Simultaneous issue/pop, then pop at full credit
      reset_init();
      for (int i = 0; i < 4; i++) cyc(0, 1, {8'(i), 8'h40}, 0, 0);
      cyc(0, 0, 16'h0, 0, 1);
      chk("t5_credit", 32'(credit), 5);
      chk("t5_sent", 32'(sent_cnt), 4);
      repeat (3) cyc(0, 0, 16'h0, 0, 1);
      chk("t5_full", 32'(credit), 8);
      chk("t5_err0", 32'(credit_err), 0);
      cyc(0, 0, 16'h0, 0, 1);
      chk("t5_over", 32'(credit), 8);
      chk("t5_err1", 32'(credit_err), 1);
      repeat (5) idle();
      chk("t5_sticky", 32'(credit_err), 1);

      // Pause buffering, release burst, reset mid-burst
      cyc(0, 0, 16'h0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, {8'(i), 8'h80}, 1, 0);
         chk("t6_paused", 32'(sw_valid_in), 0);
      end
      chk("t6_q", 32'(q_count), 4);
      idle();
      chk("t6_release", 32'(sw_valid_in), 0);
      pulses = 0;
      idle();
      if (sw_valid_in) pulses++;
      chk("t6_pkt1", 32'(sw_pkt), 32'h0080);
      idle();
      if (sw_valid_in) pulses++;
      chk("t6_pkt2", 32'(sw_pkt), 32'h0180);
      chk("t6_pulses", pulses, 2);
      cyc(1, 0, 16'h0, 0, 0);
      chk("t6_rst_valid", 32'(sw_valid_in), 0);
      chk("t6_rst_q", 32'(q_count), 0);
      chk("t6_rst_credit", 32'(credit), 8);
      chk("t6_rst_err", 32'(credit_err), 0);
      chk("t6_rst_sent", 32'(sent_cnt), 0);
      repeat (6) begin
         idle();
         chk("t6_quiet", 32'(sw_valid_in), 0);
      end

      // Random traffic against the model
      reset_init();
      for (int i = 0; i < 2000; i++) begin
         r  = ($urandom_range(0, 399) == 0);
         v  = ($urandom_range(0, 1) == 1);
         t  = 4'($urandom_range(0, 15));
         sr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15))
                                          : 4'd0;
         pz = ($urandom_range(0, 9) == 0);
         pp = ($urandom_range(0, 2) == 0);
         cyc(r, v, {8'($urandom), t, sr}, pz, pp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
